// File: rtl/zii_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zii_pkg : shared types and RAM window decode for the Zorro II cycle ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
package zii_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    ACK     = 2'd2,
    RECOVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    T_RAM  = 2'd0,
    T_ATA0 = 2'd1,
    T_ATA1 = 2'd2,
    T_ROM  = 2'd3
  } target_t;

  // RAM size in 2 MB chunks
  localparam logic [2:0] RAM_LIMIT_8MB = 3'd4;
  localparam logic [2:0] RAM_LIMIT_4MB = 3'd2;

  function automatic logic ram_window_hit(input logic [2:0] a_hi,
                                          input logic [2:0] base,
                                          input logic       jp2);
    logic [2:0] idx;
    idx = a_hi - base;
    return (idx < (jp2 ? RAM_LIMIT_8MB : RAM_LIMIT_4MB));
  endfunction

endpackage
`default_nettype wire

// File: rtl/zii_sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zii_sync2 : two-flop synchronizer for an active-low bus strobe, resets high.
// Rev 1.0
// ---------------------------------------------------------------------------
module zii_sync2 (
  input  logic CLK,
  input  logic RESET_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/zii_cycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// zii_cycle_ctrl : decodes CPU cycles into fast-RAM / IDE / boot-ROM strobes
// and terminates them with open-drain DTACK_n.  Rev 1.0
// ---------------------------------------------------------------------------
module zii_cycle_ctrl
  import zii_pkg::*;
#(
  parameter int RAM_WAIT = 1,
  parameter int IDE_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW_n,
  input  logic [23:1] A,
  input  logic        JP2,
  input  logic [7:5]  BASE_RAM,
  input  logic [7:0]  BASE_IDE,
  input  logic        RAM_CONFIGURED_n,
  input  logic        IDE_CONFIGURED_n,
  output logic        RAM_CE_n,
  output logic        RAM_OE_n,
  output logic        RAM_UB_n,
  output logic        RAM_LB_n,
  output logic        RAM_WE_n,
  output logic [1:0]  IDE_CS_n,
  output logic        IDE_IOR_n,
  output logic        IDE_IOW_n,
  output logic        ROM_OE_n,
  output wire         DTACK_n
);

  logic w_as_s_n, w_uds_s_n, w_lds_s_n;

  zii_sync2 u_sync_as  (.CLK(CLK), .RESET_n(RESET_n), .i_d(AS_n),  .o_q(w_as_s_n));
  zii_sync2 u_sync_uds (.CLK(CLK), .RESET_n(RESET_n), .i_d(UDS_n), .o_q(w_uds_s_n));
  zii_sync2 u_sync_lds (.CLK(CLK), .RESET_n(RESET_n), .i_d(LDS_n), .o_q(w_lds_s_n));

  logic w_as, w_ds;
  assign w_as = ~w_as_s_n;
  assign w_ds = ~w_uds_s_n | ~w_lds_s_n;

  // Address decode; only sampled on the IDLE->STROBE edge
  logic       w_ram_hit, w_ide_hit, w_hit;
  target_t    w_target;
  logic [3:0] w_load;
  logic       w_unused_addr;

  assign w_ram_hit = ~RAM_CONFIGURED_n & ram_window_hit(A[23:21], BASE_RAM, JP2);
  assign w_ide_hit = ~IDE_CONFIGURED_n & (A[23:16] == BASE_IDE);
  assign w_hit     = w_ram_hit | w_ide_hit;
  assign w_load    = w_ram_hit ? 4'(RAM_WAIT) : 4'(IDE_WAIT);
  assign w_unused_addr = &{A[14:13], A[11:1]};

  always_comb begin
    w_target = T_RAM;
    if (!w_ram_hit) begin
      if (!A[15])     w_target = T_ROM;
      else if (A[12]) w_target = T_ATA1;
      else            w_target = T_ATA0;
    end
  end

  state_t     r_state, w_state_nxt;
  target_t    r_target, w_target_nxt;
  logic       r_read, w_read_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [1:0] r_be, w_be_nxt;
  logic       w_count_en;

  // RAM/ATA writes hold the count until a data strobe is seen
  assign w_count_en = r_read | (r_target == T_ROM) | w_ds;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state  <= IDLE;
      r_target <= T_RAM;
      r_read   <= 1'b1;
      r_cnt    <= 4'd0;
      r_be     <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_read   <= w_read_nxt;
      r_cnt    <= w_cnt_nxt;
      r_be     <= w_be_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_read_nxt   = r_read;
    w_cnt_nxt    = r_cnt;
    w_be_nxt     = r_be;
    case (r_state)
      IDLE: begin
        if (w_as && w_hit) begin
          w_state_nxt  = STROBE;
          w_target_nxt = w_target;
          w_read_nxt   = RW_n;
          w_cnt_nxt    = w_load;
        end
      end
      STROBE: begin
        w_be_nxt = {~w_uds_s_n, ~w_lds_s_n};
        if (!w_as) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = 4'd0;
        end else if (w_count_en) begin
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ACK;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      ACK: begin
        if (!w_as) w_state_nxt = RECOVER;
      end
      RECOVER: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from registers so async reset negates them at once
  logic       w_active, w_in_ack, w_wr_ok, w_ram, w_ata;
  logic [1:0] w_be;

  assign w_in_ack = (r_state == ACK);
  assign w_active = (r_state == STROBE) | w_in_ack;
  assign w_wr_ok  = w_in_ack | w_ds;
  assign w_be     = w_in_ack ? r_be : {~w_uds_s_n, ~w_lds_s_n};
  assign w_ram    = w_active & (r_target == T_RAM);
  assign w_ata    = w_active & ((r_target == T_ATA0) | (r_target == T_ATA1));

  assign RAM_CE_n  = ~w_ram;
  assign RAM_OE_n  = ~(w_ram & r_read);
  assign RAM_WE_n  = ~(w_ram & ~r_read & w_wr_ok);
  assign RAM_UB_n  = ~(w_ram & w_be[1]);
  assign RAM_LB_n  = ~(w_ram & w_be[0]);

  // Bit 1 carries CS0, bit 0 carries CS1
  assign IDE_CS_n  = {~(w_ata & (r_target == T_ATA0)), ~(w_ata & (r_target == T_ATA1))};
  assign IDE_IOR_n = ~(w_ata & r_read);
  assign IDE_IOW_n = ~(w_ata & ~r_read & w_wr_ok);
  assign ROM_OE_n  = ~(w_active & (r_target == T_ROM) & r_read);

  assign DTACK_n = w_in_ack ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_zii_cycle_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_zii_cycle_ctrl : directed self-checking bench for zii_cycle_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_zii_cycle_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        AS_n, UDS_n, LDS_n, RW_n;
  logic [23:1] A;
  logic        JP2;
  logic [7:5]  BASE_RAM;
  logic [7:0]  BASE_IDE;
  logic        RAM_CONFIGURED_n, IDE_CONFIGURED_n;
  logic        RAM_CE_n, RAM_OE_n, RAM_UB_n, RAM_LB_n, RAM_WE_n;
  logic [1:0]  IDE_CS_n;
  logic        IDE_IOR_n, IDE_IOW_n, ROM_OE_n;
  wire         DTACK_n;

  pullup (DTACK_n);

  zii_cycle_ctrl #(.RAM_WAIT(1), .IDE_WAIT(4)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW_n(RW_n), .A(A), .JP2(JP2), .BASE_RAM(BASE_RAM), .BASE_IDE(BASE_IDE),
    .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .IDE_CONFIGURED_n(IDE_CONFIGURED_n),
    .RAM_CE_n(RAM_CE_n), .RAM_OE_n(RAM_OE_n), .RAM_UB_n(RAM_UB_n),
    .RAM_LB_n(RAM_LB_n), .RAM_WE_n(RAM_WE_n), .IDE_CS_n(IDE_CS_n),
    .IDE_IOR_n(IDE_IOR_n), .IDE_IOW_n(IDE_IOW_n), .ROM_OE_n(ROM_OE_n),
    .DTACK_n(DTACK_n)
  );

  always #5 CLK = ~CLK;

  // {CE, OE, UB, LB, WE, CS_n[1:0], IOR, IOW, ROM_OE, DTACK}
  localparam logic [10:0] c_idle       = 11'b11111_11_1111;
  localparam logic [10:0] c_ram_rd_s   = 11'b00001_11_1111;
  localparam logic [10:0] c_ram_rd_a   = 11'b00001_11_1110;
  localparam logic [10:0] c_ata1_nods  = 11'b11111_10_1111;
  localparam logic [10:0] c_ata1_wr_s  = 11'b11111_10_1011;
  localparam logic [10:0] c_ata1_wr_a  = 11'b11111_10_1010;
  localparam logic [10:0] c_rom_rd_s   = 11'b11111_11_1101;
  localparam logic [10:0] c_rom_rd_a   = 11'b11111_11_1100;
  localparam logic [10:0] c_dtack_only = 11'b11111_11_1110;
  localparam logic [10:0] c_ata0_rd_s  = 11'b11111_01_0111;
  localparam logic [10:0] c_ata0_rd_a  = 11'b11111_01_0110;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {RAM_CE_n, RAM_OE_n, RAM_UB_n, RAM_LB_n, RAM_WE_n, IDE_CS_n,
            IDE_IOR_n, IDE_IOW_n, ROM_OE_n, DTACK_n};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic rd, input logic [1:0] ds);
    A     = addr[23:1];
    RW_n  = rd;
    AS_n  = 1'b0;
    UDS_n = ~ds[1];
    LDS_n = ~ds[0];
  endtask

  task automatic end_cycle();
    AS_n  = 1'b1;
    UDS_n = 1'b1;
    LDS_n = 1'b1;
    RW_n  = 1'b1;
  endtask

  initial begin
    RESET_n = 1'b0;
    end_cycle();
    A = '0;
    JP2 = 1'b1;
    BASE_RAM = 3'b001;
    BASE_IDE = 8'hE9;
    RAM_CONFIGURED_n = 1'b0;
    IDE_CONFIGURED_n = 1'b0;
    tick(2);
    check_value("reset", 32'(outs()), 32'(c_idle));
    RESET_n = 1'b1;
    tick(3);

    // RAM read inside 8 MB window
    start_cycle(24'h9FFFFE, 1'b1, 2'b11);
    tick(2); check_value("ram_rd_pre", 32'(outs()), 32'(c_idle));
    tick(1); check_value("ram_rd_strobe", 32'(outs()), 32'(c_ram_rd_s));
    tick(1); check_value("ram_rd_ack", 32'(outs()), 32'(c_ram_rd_a));
    end_cycle();
    tick(2); check_value("ram_rd_hold", 32'(outs()), 32'(c_ram_rd_a));
    tick(1); check_value("ram_rd_recover", 32'(outs()), 32'(c_idle));
    tick(1);

    // Just above the 8 MB window
    start_cycle(24'hA00000, 1'b1, 2'b11);
    tick(4); check_value("ram_8mb_miss", 32'(outs()), 32'(c_idle));
    end_cycle();
    tick(3);

    // 4 MB window
    JP2 = 1'b0;
    start_cycle(24'h600000, 1'b1, 2'b11);
    tick(4); check_value("ram_4mb_miss", 32'(outs()), 32'(c_idle));
    end_cycle();
    tick(3);
    start_cycle(24'h5FFFFE, 1'b1, 2'b11);
    tick(3); check_value("ram_4mb_strobe", 32'(outs()), 32'(c_ram_rd_s));
    tick(1); check_value("ram_4mb_ack", 32'(outs()), 32'(c_ram_rd_a));
    end_cycle();
    tick(4);

    // ATA CS1 byte write, LDS arrives after the strobe state is entered
    start_cycle(24'hE99000, 1'b0, 2'b00);
    tick(3); check_value("ata_wr_nods", 32'(outs()), 32'(c_ata1_nods));
    LDS_n = 1'b0;
    tick(2); check_value("ata_wr_iow", 32'(outs()), 32'(c_ata1_wr_s));
    tick(3); check_value("ata_wr_wait", 32'(outs()), 32'(c_ata1_wr_s));
    tick(1); check_value("ata_wr_ack", 32'(outs()), 32'(c_ata1_wr_a));
    end_cycle();
    tick(4); check_value("ata_wr_idle", 32'(outs()), 32'(c_idle));

    // Boot ROM read and write
    start_cycle(24'hE90000, 1'b1, 2'b11);
    tick(3); check_value("rom_rd_strobe", 32'(outs()), 32'(c_rom_rd_s));
    tick(3); check_value("rom_rd_wait", 32'(outs()), 32'(c_rom_rd_s));
    tick(1); check_value("rom_rd_ack", 32'(outs()), 32'(c_rom_rd_a));
    end_cycle();
    tick(4);
    start_cycle(24'hE90000, 1'b0, 2'b11);
    tick(3); check_value("rom_wr_nostrobe", 32'(outs()), 32'(c_idle));
    tick(4); check_value("rom_wr_ack", 32'(outs()), 32'(c_dtack_only));
    end_cycle();
    tick(4);

    // IDE window disabled
    IDE_CONFIGURED_n = 1'b1;
    start_cycle(24'hE90000, 1'b1, 2'b11);
    tick(5); check_value("ide_unconf", 32'(outs()), 32'(c_idle));
    end_cycle();
    tick(3);
    IDE_CONFIGURED_n = 1'b0;

    // Aborted ROM read: AS released before the count expires
    start_cycle(24'hE90000, 1'b1, 2'b11);
    tick(3); check_value("abort_strobe", 32'(outs()), 32'(c_rom_rd_s));
    end_cycle();
    tick(2); check_value("abort_hold", 32'(outs()), 32'(c_rom_rd_s));
    tick(1); check_value("abort_recover", 32'(outs()), 32'(c_idle));
    tick(1); check_value("abort_no_ack", 32'(outs()), 32'(c_idle));
    tick(2);

    // Async reset during ATA CS0 read acknowledge
    start_cycle(24'hE98000, 1'b1, 2'b11);
    tick(3); check_value("ata_rd_strobe", 32'(outs()), 32'(c_ata0_rd_s));
    tick(4); check_value("ata_rd_ack", 32'(outs()), 32'(c_ata0_rd_a));
    #2 RESET_n = 1'b0;
    #1 check_value("rst_async", 32'(outs()), 32'(c_idle));
    @(negedge CLK);
    end_cycle();
    RESET_n = 1'b1;
    tick(2);
    start_cycle(24'hE98000, 1'b1, 2'b11);
    tick(3); check_value("post_rst_strobe", 32'(outs()), 32'(c_ata0_rd_s));
    tick(4); check_value("post_rst_ack", 32'(outs()), 32'(c_ata0_rd_a));
    end_cycle();
    tick(4); check_value("post_rst_idle", 32'(outs()), 32'(c_idle));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/zii_cycle_ctrl.md
# zii_cycle_ctrl

Bus-cycle controller that sits downstream of the Zorro II autoconfig block. It consumes the assigned base addresses and configured flags, decodes CPU cycles into the fast-RAM window and the 64 KB IDE window, and drives the RAM strobes, IDE strobes and boot-ROM output enable. It also terminates every decoded cycle with DTACK_n after a per-target wait-state count. Undecoded cycles are left untouched for the motherboard to terminate.

## Interface
- RAM_WAIT, default 1: CLK cycles between strobe assertion and DTACK_n for RAM.
- IDE_WAIT, default 4: CLK cycles between strobe assertion and DTACK_n for IDE and ROM; range 1..15.
- CLK  in  1  7.09 MHz CPU bus clock.
- RESET_n  in  1  reset, asynchronous, active-low.
- AS_n, UDS_n, LDS_n, RW_n  in  1 each  68000 bus strobes, asynchronous to CLK.
- A  in  [23:1]  CPU address.
- JP2  in  1  RAM size: 1 = 8 MB, 0 = 4 MB.
- BASE_RAM  in  [7:5]  RAM base, 2 MB granularity, from autoconfig.
- BASE_IDE  in  [7:0]  IDE base, A[23:16], from autoconfig.
- RAM_CONFIGURED_n, IDE_CONFIGURED_n  in  1 each  window enables; low = valid.
- RAM_CE_n, RAM_OE_n, RAM_UB_n, RAM_LB_n, RAM_WE_n  out  1 each  SRAM controls.
- IDE_CS_n  out  [1:0]  ATA CS0/CS1.
- IDE_IOR_n, IDE_IOW_n  out  1 each  ATA read/write strobes.
- ROM_OE_n  out  1  boot ROM output enable.
- DTACK_n  out  1  cycle termination, open-drain style: driven low only, otherwise Z.

## Operation
- AS_n, UDS_n and LDS_n pass through two-flop synchronizers. All decisions use the synchronized values.
- RAM hit: RAM_CONFIGURED_n=0 and idx < limit, where idx = (A[23:21] − BASE_RAM) mod 8 (3-bit wrap) and limit = 4 when JP2=1, 2 when JP2=0.
- IDE-window hit: IDE_CONFIGURED_n=0 and A[23:16]==BASE_IDE. RAM decode takes priority if both match.
- Inside the IDE window:
  - A[15]=0 selects ROM. Reads only; a write is acknowledged but asserts no strobe.
  - A[15]=1 selects ATA. A[12]=0 → CS0, A[12]=1 → CS1.
- States:
  - IDLE: AS low and hit → STROBE. Latch the target and load the counter with RAM_WAIT or IDE_WAIT.
  - STROBE: assert the target strobes. Counter decrements each cycle; at 0 → ACK.
  - ACK: DTACK_n low, strobes held. AS high → RECOVER.
  - RECOVER: all outputs negated for one cycle → IDLE.
- AS low with no hit: stay IDLE, drive nothing.
- Strobe mapping:
  - RAM read: CE, OE, and UB/LB mirroring UDS/LDS.
  - RAM write: CE, WE, UB/LB.
  - ATA read: CSx + IOR. ATA write: CSx + IOW.
  - ROM read: ROM_OE_n.
- The target, RW_n and address decode are latched on the IDLE→STROBE edge. Mid-cycle changes to A or BASE_* are ignored.
- Reset values: all strobe outputs 1, IDE_CS_n=2'b11, DTACK_n=Z, state IDLE, counter 0.

## Timing
- AS falling edge to STROBE entry: 2–3 CLK (synchronizer plus one decode cycle).
- Strobes to DTACK_n low: exactly RAM_WAIT or IDE_WAIT CLK.
- AS rising edge to strobe and DTACK negation: 2–3 CLK. DTACK_n releases to Z in the same cycle the strobes negate.
- Write cycles for RAM and ATA: WE/IOW asserts only once synchronized UDS or LDS is low. The counter does not start until then.
- RESET_n low at any point: state and outputs return to reset values asynchronously, within the same CLK period. No DTACK_n is left asserted.
- AS negated before the count expires (aborted cycle): go directly to RECOVER, with no DTACK_n.

## Structure
- Shared package zii_pkg holds:
  - state enum {IDLE, STROBE, ACK, RECOVER}
  - target enum {T_RAM, T_ATA0, T_ATA1, T_ROM}
  - RAM size limits, 4 and 2 chunks
- Sub-module zii_sync2: a 2-flop synchronizer instantiated per asynchronous strobe, reset to 1 by RESET_n.

## Test plan
- BASE_RAM=3'b001, JP2=1. Read at 0x9FFFFE → RAM_CE_n/RAM_OE_n low; DTACK_n low 1 CLK later. Read at 0xA00000 → no strobes, DTACK_n=Z.
- JP2=0, BASE_RAM=3'b001. Access at 0x600000 → no hit. Access at 0x5FFFFE → RAM hit.
- BASE_IDE=8'hE9. Byte write, LDS only, to 0xE99000 → IDE_CS_n=2'b10 (CS1 low), IDE_IOW_n low; DTACK_n low exactly 4 CLK after IOW.
- Read at 0xE90000 → ROM_OE_n low. Write at 0xE90000 → DTACK_n asserted, ROM_OE_n stays 1.
- IDE_CONFIGURED_n=1 and a read at base → IDLE held, every output at its reset value.
- RESET_n pulsed low during the ACK state of an ATA cycle → all strobes high and DTACK_n=Z before the next CLK edge; after release, the next cycle completes normally.
